// File: rtl/mdu_ctrl_if.sv
// Operation, result and divider handshake bundle between the pipeline and mdu_ctrl.
// The pipeline/divider side holds the master modport; mdu_ctrl holds slave.
interface mdu_ctrl_if;
  logic        Op_valid;
  logic [2:0]  Op;
  logic [31:0] Src_A;
  logic [31:0] Src_B;
  logic        Flush;
  logic        Busy;
  logic [31:0] Hi_out;
  logic [31:0] Lo_out;
  logic        Div_start;
  logic        Div_sign;
  logic [31:0] Div_A;
  logic [31:0] Div_B;
  logic        Div_done;
  logic [31:0] Div_hi;
  logic [31:0] Div_lo;

  modport master (
    output Op_valid, Op, Src_A, Src_B, Flush, Div_done, Div_hi, Div_lo,
    input  Busy, Hi_out, Lo_out, Div_start, Div_sign, Div_A, Div_B
  );

  modport slave (
    input  Op_valid, Op, Src_A, Src_B, Flush, Div_done, Div_hi, Div_lo,
    output Busy, Hi_out, Lo_out, Div_start, Div_sign, Div_A, Div_B
  );
endinterface

// File: rtl/mdu_ctrl.sv
// HI/LO multiply-divide sequencer: MUL_STAGES+1 cycle multiply, external divider handshake.
// Busy stalls the pipeline in every non-IDLE state; ops are only accepted while Busy is low.
module mdu_ctrl #(
  parameter int MUL_STAGES = 2
) (
  input  logic     Clk,
  input  logic     Resetn,
  mdu_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, MUL, DIV_LAUNCH, DIV_WAIT, DIV_DRAIN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t       state, state_nxt;
  logic [2:0]   cnt, cnt_nxt;
  logic [31:0]  hi_q, lo_q, hi_nxt, lo_nxt;
  logic         div_sign_q;
  logic [31:0]  div_a_q, div_b_q;
  logic [63:0]  pipe [MUL_STAGES];
  logic         accept, mul_ld, div_ld, mul_sx;
  logic signed [63:0] mul_a, mul_b, mul_p;

  assign accept = bus.Op_valid && (state == IDLE) && !bus.Flush;
  assign mul_ld = accept && (bus.Op == OP_MULT || bus.Op == OP_MULTU);
  assign div_ld = accept && (bus.Op == OP_DIV || bus.Op == OP_DIVU) && (bus.Src_B != '0);

  // Operands are extended to 64 bits so one signed multiplier covers MULT and MULTU.
  assign mul_sx = (bus.Op == OP_MULT);
  assign mul_a  = {{32{mul_sx & bus.Src_A[31]}}, bus.Src_A};
  assign mul_b  = {{32{mul_sx & bus.Src_B[31]}}, bus.Src_B};
  assign mul_p  = mul_a * mul_b;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      for (int k = 0; k < MUL_STAGES; k++) pipe[k] <= '0;
    end else begin
      if (mul_ld) pipe[0] <= mul_p;
      for (int k = 1; k < MUL_STAGES; k++) pipe[k] <= pipe[k-1];
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_sign_q <= 1'b0;
      div_a_q    <= '0;
      div_b_q    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
      if (div_ld) begin
        div_sign_q <= (bus.Op == OP_DIV);
        div_a_q    <= bus.Src_A;
        div_b_q    <= bus.Src_B;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hi_nxt    = hi_q;
    lo_nxt    = lo_q;
    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.Op)
            OP_MULT, OP_MULTU: begin
              state_nxt = MUL;
              cnt_nxt   = 3'(MUL_STAGES);
            end
            OP_DIV, OP_DIVU: if (bus.Src_B != '0) state_nxt = DIV_LAUNCH;
            OP_MTHI: hi_nxt = bus.Src_A;
            OP_MTLO: lo_nxt = bus.Src_A;
            default: ;
          endcase
        end
      end
      MUL: begin
        if (bus.Flush) begin
          state_nxt = IDLE;
        end else if (cnt == 3'd1) begin
          state_nxt = IDLE;
          hi_nxt    = pipe[MUL_STAGES-1][63:32];
          lo_nxt    = pipe[MUL_STAGES-1][31:0];
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      DIV_LAUNCH: state_nxt = bus.Flush ? DIV_DRAIN : DIV_WAIT;
      DIV_WAIT: begin
        // A flush landing on the same cycle as the result still discards it.
        if (bus.Flush) begin
          state_nxt = bus.Div_done ? IDLE : DIV_DRAIN;
        end else if (bus.Div_done) begin
          state_nxt = IDLE;
          hi_nxt    = bus.Div_hi;
          lo_nxt    = bus.Div_lo;
        end
      end
      DIV_DRAIN: if (bus.Div_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign bus.Busy      = (state != IDLE);
  assign bus.Div_start = (state == DIV_LAUNCH);
  assign bus.Div_sign  = div_sign_q;
  assign bus.Div_A     = div_a_q;
  assign bus.Div_B     = div_b_q;
  assign bus.Hi_out    = hi_q;
  assign bus.Lo_out    = lo_q;

endmodule
